// File: rtl/vga_pkg.sv
// Shared types and default 640x480 @ 25 MHz timing for the VGA timing generator.
// Holds the per-axis state encoding and a width-fit helper for counter sizing.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_FRONT,
    ST_SYNC,
    ST_BACK
  } axis_state_t;

  localparam int DEF_VIDEO_WIDTH      = 3;
  localparam int DEF_ACTIVE_COLS      = 640;
  localparam int DEF_FRONT_PORCH_HORZ = 16;
  localparam int DEF_SYNC_HORZ        = 96;
  localparam int DEF_BACK_PORCH_HORZ  = 48;
  localparam int DEF_ACTIVE_ROWS      = 480;
  localparam int DEF_FRONT_PORCH_VERT = 10;
  localparam int DEF_SYNC_VERT        = 2;
  localparam int DEF_BACK_PORCH_VERT  = 33;
  localparam int DEF_SYNC_ACTIVE_LOW  = 1;
  localparam int DEF_VIDEO_DELAY      = 2;
  localparam int DEF_COUNT_WIDTH      = 10;

  // True when a counter of 'width' bits can reach total-1.
  function automatic bit fits_width(input int total, input int width);
    return total <= (1 << width);
  endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// One axis of the raster: tracks ACTIVE/FRONT/SYNC/BACK from the shared counter.
// Used once for columns (advance every enabled clock) and once for rows (advance on line wrap).
module vga_axis_timer
  import vga_pkg::*;
#(
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   clear,
  input  logic                   advance,
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic [COUNT_WIDTH-1:0] active_len,
  input  logic [COUNT_WIDTH-1:0] front_len,
  input  logic [COUNT_WIDTH-1:0] sync_len,
  input  logic [COUNT_WIDTH-1:0] back_len,
  output axis_state_t            state,
  output logic                   wrap,
  output logic                   in_sync
);

  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

  logic [COUNT_WIDTH-1:0] end_active;
  logic [COUNT_WIDTH-1:0] end_front;
  logic [COUNT_WIDTH-1:0] end_sync;
  logic [COUNT_WIDTH-1:0] end_back;

  // Last count value of each region; a region is left on the advance that leaves that value.
  assign end_active = active_len - ONE;
  assign end_front  = end_active + front_len;
  assign end_sync   = end_front + sync_len;
  assign end_back   = end_sync + back_len;

  assign wrap    = advance && (count == end_back);
  assign in_sync = (state == ST_SYNC);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state <= ST_ACTIVE;
    end else if (clear) begin
      state <= ST_ACTIVE;
    end else if (advance) begin
      case (state)
        ST_ACTIVE: if (count == end_active) state <= ST_FRONT;
        ST_FRONT:  if (count == end_front)  state <= ST_SYNC;
        ST_SYNC:   if (count == end_sync)   state <= ST_BACK;
        ST_BACK:   if (count == end_back)   state <= ST_ACTIVE;
        default:   state <= ST_ACTIVE;
      endcase
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: raster counters, per-axis region tracking,
// and a delay line that re-aligns returned pixel video with HSync/VSync.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int VIDEO_WIDTH      = DEF_VIDEO_WIDTH,
  parameter int ACTIVE_COLS      = DEF_ACTIVE_COLS,
  parameter int FRONT_PORCH_HORZ = DEF_FRONT_PORCH_HORZ,
  parameter int SYNC_HORZ        = DEF_SYNC_HORZ,
  parameter int BACK_PORCH_HORZ  = DEF_BACK_PORCH_HORZ,
  parameter int ACTIVE_ROWS      = DEF_ACTIVE_ROWS,
  parameter int FRONT_PORCH_VERT = DEF_FRONT_PORCH_VERT,
  parameter int SYNC_VERT        = DEF_SYNC_VERT,
  parameter int BACK_PORCH_VERT  = DEF_BACK_PORCH_VERT,
  parameter int SYNC_ACTIVE_LOW  = DEF_SYNC_ACTIVE_LOW,
  parameter int VIDEO_DELAY      = DEF_VIDEO_DELAY,
  parameter int COUNT_WIDTH      = DEF_COUNT_WIDTH
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_Enable,
  input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
  output logic [COUNT_WIDTH-1:0] o_Col_Count,
  output logic [COUNT_WIDTH-1:0] o_Row_Count,
  output logic                   o_Active,
  output logic                   o_Frame_Start,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video
);

  localparam int TOTAL_COLS = ACTIVE_COLS + FRONT_PORCH_HORZ + SYNC_HORZ + BACK_PORCH_HORZ;
  localparam int TOTAL_ROWS = ACTIVE_ROWS + FRONT_PORCH_VERT + SYNC_VERT + BACK_PORCH_VERT;
  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);
  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

  if (!fits_width(TOTAL_COLS, COUNT_WIDTH) || !fits_width(TOTAL_ROWS, COUNT_WIDTH)) begin : g_bad_width
    $fatal(1, "vga_timing_gen: COUNT_WIDTH too small for the configured raster");
  end
  if (VIDEO_DELAY < 1 || VIDEO_DELAY > 8) begin : g_bad_delay
    $fatal(1, "vga_timing_gen: VIDEO_DELAY must be in 1..8");
  end

  logic [COUNT_WIDTH-1:0] col_count;
  logic [COUNT_WIDTH-1:0] row_count;
  axis_state_t            h_state;
  axis_state_t            v_state;
  logic                   h_wrap;
  logic                   v_wrap;
  logic                   h_in_sync;
  logic                   v_in_sync;
  logic                   run_q;
  logic                   run_en;
  logic                   active_now;

  logic [VIDEO_DELAY-1:0] hs_pipe;
  logic [VIDEO_DELAY-1:0] vs_pipe;
  logic [VIDEO_DELAY-1:0] act_pipe;

  // Enable is qualified by a registered copy so the raster always restarts from
  // a clean origin cycle after reset release or an idle period.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      run_q <= 1'b0;
    end else begin
      run_q <= i_Enable;
    end
  end

  assign run_en = i_Enable && run_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      col_count <= '0;
      row_count <= '0;
    end else if (!run_en) begin
      col_count <= '0;
      row_count <= '0;
    end else begin
      col_count <= h_wrap ? '0 : col_count + ONE;
      if (h_wrap) begin
        row_count <= v_wrap ? '0 : row_count + ONE;
      end
    end
  end

  vga_axis_timer #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_horz (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .clear      (!run_en),
    .advance    (run_en),
    .count      (col_count),
    .active_len (COUNT_WIDTH'(ACTIVE_COLS)),
    .front_len  (COUNT_WIDTH'(FRONT_PORCH_HORZ)),
    .sync_len   (COUNT_WIDTH'(SYNC_HORZ)),
    .back_len   (COUNT_WIDTH'(BACK_PORCH_HORZ)),
    .state      (h_state),
    .wrap       (h_wrap),
    .in_sync    (h_in_sync)
  );

  vga_axis_timer #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_vert (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .clear      (!run_en),
    .advance    (h_wrap),
    .count      (row_count),
    .active_len (COUNT_WIDTH'(ACTIVE_ROWS)),
    .front_len  (COUNT_WIDTH'(FRONT_PORCH_VERT)),
    .sync_len   (COUNT_WIDTH'(SYNC_VERT)),
    .back_len   (COUNT_WIDTH'(BACK_PORCH_VERT)),
    .state      (v_state),
    .wrap       (v_wrap),
    .in_sync    (v_in_sync)
  );

  assign active_now    = run_en && (h_state == ST_ACTIVE) && (v_state == ST_ACTIVE);
  assign o_Active      = active_now;
  assign o_Frame_Start = active_now && (col_count == '0) && (row_count == '0);
  assign o_Col_Count   = col_count;
  assign o_Row_Count   = row_count;

  // Sync and active travel active-high through the pipe; polarity is applied at the pins.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hs_pipe  <= '0;
      vs_pipe  <= '0;
      act_pipe <= '0;
    end else begin
      hs_pipe[0]  <= run_en && h_in_sync;
      vs_pipe[0]  <= run_en && v_in_sync;
      act_pipe[0] <= active_now;
      for (int i = 1; i < VIDEO_DELAY; i++) begin
        hs_pipe[i]  <= hs_pipe[i-1];
        vs_pipe[i]  <= vs_pipe[i-1];
        act_pipe[i] <= act_pipe[i-1];
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_HSync     <= SYNC_IDLE;
      o_VSync     <= SYNC_IDLE;
      o_Red_Video <= '0;
      o_Grn_Video <= '0;
      o_Blu_Video <= '0;
    end else begin
      o_HSync     <= hs_pipe[VIDEO_DELAY-1] ^ SYNC_IDLE;
      o_VSync     <= vs_pipe[VIDEO_DELAY-1] ^ SYNC_IDLE;
      o_Red_Video <= act_pipe[VIDEO_DELAY-1] ? i_Red_Video : '0;
      o_Grn_Video <= act_pipe[VIDEO_DELAY-1] ? i_Grn_Video : '0;
      o_Blu_Video <= act_pipe[VIDEO_DELAY-1] ? i_Blu_Video : '0;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Self-contained, parametrised VGA timing generator that replaces the external sync-generator plus porch-fixup pair. It owns the column/row counters and runs a per-axis ACTIVE/FRONT/SYNC/BACK state machine. It exports pixel coordinates to the pixel generator and re-aligns the returned video with HSync/VSync through a configurable pipeline. Video is forced to zero outside the active area; it sits between the game/pixel logic and the VGA pins.

Parameters:
VIDEO_WIDTH, 3, bits per colour channel
ACTIVE_COLS, 640, visible pixels per line
FRONT_PORCH_HORZ, 16, horizontal front porch in clocks
SYNC_HORZ, 96, HSync pulse width in clocks
BACK_PORCH_HORZ, 48, horizontal back porch in clocks
ACTIVE_ROWS, 480, visible lines per frame
FRONT_PORCH_VERT, 10, vertical front porch in lines
SYNC_VERT, 2, VSync pulse width in lines
BACK_PORCH_VERT, 33, vertical back porch in lines
SYNC_ACTIVE_LOW, 1, 1 = sync pulses drive 0, 0 = sync pulses drive 1
VIDEO_DELAY, 2, clocks from o_Col_Count/o_Row_Count to valid i_*_Video (legal 1..8)
COUNT_WIDTH, 10, counter width; must hold TOTAL_COLS-1 and TOTAL_ROWS-1

Ports:
i_Clk  in  1  pixel clock (25 MHz for 640x480)
i_Rst_L  in  1  asynchronous active-low reset
i_Enable  in  1  run timing; low = idle and hold at origin
i_Red_Video  in  VIDEO_WIDTH  pixel red, VIDEO_DELAY clocks after coordinates
i_Grn_Video  in  VIDEO_WIDTH  pixel green, same alignment
i_Blu_Video  in  VIDEO_WIDTH  pixel blue, same alignment
o_Col_Count  out  COUNT_WIDTH  current column 0..TOTAL_COLS-1
o_Row_Count  out  COUNT_WIDTH  current row 0..TOTAL_ROWS-1
o_Active  out  1  coordinates are inside the visible area (undelayed)
o_Frame_Start  out  1  one-clock pulse when col=0,row=0 (undelayed)
o_HSync  out  1  delayed horizontal sync, polarity per SYNC_ACTIVE_LOW
o_VSync  out  1  delayed vertical sync, polarity per SYNC_ACTIVE_LOW
o_Red_Video  out  VIDEO_WIDTH  delayed, blanked red
o_Grn_Video  out  VIDEO_WIDTH  delayed, blanked green
o_Blu_Video  out  VIDEO_WIDTH  delayed, blanked blue

Behaviour:
- TOTAL_COLS = ACTIVE_COLS+FRONT_PORCH_HORZ+SYNC_HORZ+BACK_PORCH_HORZ (800). TOTAL_ROWS is built the same way from the vertical parameters (525).
- Reset (async assert, sync release): counters 0; axis states ACTIVE; o_HSync/o_VSync at inactive level (1 if SYNC_ACTIVE_LOW else 0); o_*_Video 0; o_Active 0; o_Frame_Start 0; whole delay pipeline cleared to inactive/zero.
- Column counter: increments every enabled clock and wraps TOTAL_COLS-1 -> 0. The row counter increments on that wrap and wraps TOTAL_ROWS-1 -> 0.
- Horizontal FSM: ACTIVE [0,AC) -> FRONT [AC,AC+FP) -> SYNC [AC+FP,AC+FP+SW) -> BACK -> ACTIVE on column wrap.
- Vertical FSM: same four states, advancing only on column wrap, using the vertical parameters.
- Sync level is asserted while the axis is in SYNC. Horizontal sync keeps running during vertical blanking.
- o_Active = (H state ACTIVE) and (V state ACTIVE). o_Frame_Start = o_Active at col 0, row 0. Both are combinational from registered state and counters.
- Delay line: HSync, VSync and Active go through VIDEO_DELAY register stages. On the clock after i_*_Video is sampled, o_*_Video = delayed Active ? i_*_Video : 0. Total coordinate-to-pin latency is VIDEO_DELAY+1 clocks for video and sync alike, so they stay aligned.
- i_Enable low: counters are synchronously cleared to 0 and held; axis states ACTIVE; sync inputs to the delay line are inactive; Active is 0. The pipeline keeps flushing, so pins go idle after VIDEO_DELAY+1 clocks.
- i_Enable rising: first enabled clock is col 0/row 0 with o_Frame_Start high. The frame never starts mid-screen.
- Reset asserted mid-frame: all outputs go to reset values immediately, with no partial-line glitch after release.
- Counter arithmetic is unsigned COUNT_WIDTH. Width overflow is a configuration error, guarded by an elaboration-time check that stops simulation.

Decomposition:
- Shared package vga_pkg: axis-state enum (ST_ACTIVE, ST_FRONT, ST_SYNC, ST_BACK) and the 640x480@25 MHz default timing constants.
- One natural sub-module, vga_axis_timer, instantiated twice (horizontal and vertical). It takes counter, advance-strobe and the four region lengths, and outputs state, wrap and in_sync.

Test Plan:
- Reset values: hold i_Rst_L=0 across clocks -> o_HSync=o_VSync=1, videos 0, counts 0. Release -> o_Frame_Start=1 on the first clock with i_Enable=1.
- Line timing: defaults, 2 lines -> HSync low exactly 96 clocks, starting 656+3 clocks after col 0, with period 800 clocks.
- Frame timing: run 2 frames -> VSync low for 1600 clocks starting at row 490; o_Frame_Start period 420000 clocks.
- Blanking and alignment: drive i_*_Video=3'b111 constantly -> o_*_Video=7 for exactly 640 clocks per active line, 0 elsewhere. Rising edge lands 3 clocks after col 0.
- Parameter variant: SYNC_ACTIVE_LOW=0, VIDEO_DELAY=4, ACTIVE_COLS=8, porches 2/2/2, rows 4/1/1/1 -> positive sync pulses; video and syncs shifted by 5 clocks; counter wraps at 14 and 7.
- Enable/reset mid-frame: drop i_Enable at row 100 -> syncs inactive after 3 clocks; re-enable -> restart at col 0/row 0. Pulse i_Rst_L low at row 300 -> immediate reset levels.
